// File: rtl/btn_press_classifier.sv
// btn_press_classifier
// Turns the debouncer's one-cycle press/release pulses into short-press,
// double-click, long-press and auto-repeat event pulses, plus a hold level
// that stays high while a long press is in progress.
module btn_press_classifier #(
    parameter int          CNT_WIDTH   = 16,
    parameter logic [15:0] LONG_CYCLES = 16'd50000,
    parameter logic [15:0] GAP_CYCLES  = 16'd20000,
    parameter logic [15:0] REP_CYCLES  = 16'd10000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic press_i,
    input  logic release_i,
    output logic short_o,
    output logic double_o,
    output logic long_o,
    output logic rep_o,
    output logic hold_o
);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        WAIT_GAP,
        SECOND,
        LONG_HELD
    } state_t;

    // Terminal counts: the timeout fires on the edge where cnt equals N-1.
    localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 16'd1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 16'd1);
    localparam logic [CNT_WIDTH-1:0] REP_LAST  = CNT_WIDTH'(REP_CYCLES - 16'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 short_d, double_d, long_d, rep_d, hold_d;
    logic                 press_ev, release_ev;

    // A press and release arriving together cancel out and count as nothing.
    assign press_ev   = press_i & ~release_i;
    assign release_ev = release_i & ~press_i;

    // State, counter and registered event outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            short_o  <= 1'b0;
            double_o <= 1'b0;
            long_o   <= 1'b0;
            rep_o    <= 1'b0;
            hold_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_o  <= short_d;
            double_o <= double_d;
            long_o   <= long_d;
            rep_o    <= rep_d;
            hold_o   <= hold_d;
        end
    end

    // Next-state and event decode; exit events take priority over timeouts.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        rep_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (press_ev) begin
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                if (release_ev) begin
                    state_d = WAIT_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG_HELD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_GAP: begin
                if (press_ev) begin
                    state_d = SECOND;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SECOND: begin
                cnt_d = '0;
                if (release_ev) begin
                    state_d  = IDLE;
                    double_d = 1'b1;
                end
            end
            LONG_HELD: begin
                if (release_ev) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d = '0;
                    rep_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        hold_d = (state_d == LONG_HELD);
    end

endmodule

// File: tb/tb_btn_press_classifier.sv
// tb_btn_press_classifier
// Directed scenarios with LONG=8, GAP=4, REP=3. Each table row lists the
// edges at which inputs are pulsed and the edges after which each output
// pulse is expected; every output is checked after every edge.
module tb_btn_press_classifier;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic press_i = 1'b0;
    logic release_i = 1'b0;
    logic short_o, double_o, long_o, rep_o, hold_o;

    int total = 0;
    int bad   = 0;

    localparam int NUM_EDGES = 40;

    typedef struct {
        int p1, r1, p2, r2;    // press / release pulse edges (0 = unused)
        int b1, b2;            // edges with press and release together
        int rs;                // edge during which reset is held high
        int e_short, e_double, e_long;
        int h_rise, h_fall;    // hold high after edges h_rise .. h_fall-1
        int rep1, rep2;
    } vec_t;

    vec_t vecs[8];

    btn_press_classifier #(
        .CNT_WIDTH  (16),
        .LONG_CYCLES(16'd8),
        .GAP_CYCLES (16'd4),
        .REP_CYCLES (16'd3)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .press_i  (press_i),
        .release_i(release_i),
        .short_o  (short_o),
        .double_o (double_o),
        .long_o   (long_o),
        .rep_o    (rep_o),
        .hold_o   (hold_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " short"},  short_o,  1'b0);
        checkOutput({tag, " double"}, double_o, 1'b0);
        checkOutput({tag, " long"},   long_o,   1'b0);
        checkOutput({tag, " rep"},    rep_o,    1'b0);
        checkOutput({tag, " hold"},   hold_o,   1'b0);
    endtask

    task automatic driveFor(input vec_t v, input int k);
        press_i   = (k == v.p1) || (k == v.p2) || (k == v.b1) || (k == v.b2);
        release_i = (k == v.r1) || (k == v.r2) || (k == v.b1) || (k == v.b2);
        if (k == v.rs) rst_i = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        // Clean reset between scenarios.
        @(negedge clk_i);
        press_i   = 1'b0;
        release_i = 1'b0;
        rst_i     = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        checkAllZero($sformatf("v%0d reset", idx));
        driveFor(v, 1);
        for (int k = 1; k <= NUM_EDGES; k++) begin
            @(negedge clk_i);
            tag = $sformatf("v%0d e%0d", idx, k);
            checkOutput({tag, " short"},  short_o,  logic'(k == v.e_short));
            checkOutput({tag, " double"}, double_o, logic'(k == v.e_double));
            checkOutput({tag, " long"},   long_o,   logic'(k == v.e_long));
            checkOutput({tag, " rep"},    rep_o,    logic'(k == v.rep1 || k == v.rep2));
            checkOutput({tag, " hold"},   hold_o,
                        logic'(v.h_rise != 0 && k >= v.h_rise && k < v.h_fall));
            if (k == v.rs) rst_i = 1'b0;
            driveFor(v, k + 1);
        end
        press_i   = 1'b0;
        release_i = 1'b0;
    endtask

    initial begin
        //          p1  r1  p2  r2  b1 b2 rs  shrt dbl lng hr  hf  rp1 rp2
        vecs[0] = '{10, 13, 0,  0,  0, 0, 0,  17,  0,  0,  0,  0,  0,  0};  // short press
        vecs[1] = '{10, 25, 0,  0,  0, 0, 0,  0,   0,  18, 18, 25, 21, 24}; // long + repeat
        vecs[2] = '{10, 12, 14, 15, 0, 0, 0,  0,   15, 0,  0,  0,  0,  0};  // double click
        vecs[3] = '{10, 12, 16, 17, 0, 0, 0,  0,   17, 0,  0,  0,  0,  0};  // gap boundary
        vecs[4] = '{10, 18, 0,  0,  0, 0, 0,  22,  0,  0,  0,  0,  0,  0};  // long boundary
        vecs[5] = '{10, 23, 30, 31, 0, 0, 20, 35,  0,  18, 18, 20, 0,  0};  // reset abort
        vecs[6] = '{5,  14, 0,  0,  3, 7, 0,  0,   0,  13, 13, 14, 0,  0};  // simultaneous p+r
        vecs[7] = '{2,  3,  5,  20, 0, 0, 0,  0,   20, 0,  0,  0,  0,  0};  // long 2nd press

        // Power-on reset state, checked while reset is asserted.
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checkAllZero("por");
        rst_i = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Asynchronous reset must clear hold_o without waiting for an edge.
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i   = 1'b0;
        press_i = 1'b1;
        @(negedge clk_i);
        press_i = 1'b0;
        repeat (8) @(negedge clk_i);
        checkOutput("async pre hold", hold_o, 1'b1);
        #2 rst_i = 1'b1;
        #1 checkOutput("async hold", hold_o, 1'b0);
        checkOutput("async long", long_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_press_classifier.md
# btn_press_classifier

Classifies debounced button activity into short-press, long-press, double-click and auto-repeat events. Sits directly downstream of the switch debouncer and consumes its one-cycle press/release pulses. Emits one-cycle registered event pulses plus a hold level for the control logic and UI logic further down.

## Interface

- LONG_CYCLES, 16'd50000: cycles a press must be held to count as a long press (≥1)
- GAP_CYCLES, 16'd20000: maximum cycles between first release and second press for a double click (≥1)
- REP_CYCLES, 16'd10000: auto-repeat period while a long press is held (≥1)
- CNT_WIDTH, 16: counter width; must hold max(LONG_CYCLES, GAP_CYCLES, REP_CYCLES)−1

- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- press_i  input  1  one-cycle pulse: debounced button pressed
- release_i  input  1  one-cycle pulse: debounced button released
- short_o  output  1  one-cycle pulse: single short press completed
- double_o  output  1  one-cycle pulse: double click completed
- long_o  output  1  one-cycle pulse: long-press threshold reached
- rep_o  output  1  one-cycle pulse: auto-repeat tick during long hold
- hold_o  output  1  level: long press in progress

## Operation

- Reset: state IDLE, cnt=0, all outputs 0. Reset mid-operation aborts without emitting any pulse.
- press_i and release_i both high in one cycle: treated as no event.
- Counter rule in every timed state: cnt cleared to 0 on state entry; each later edge with no exit event: if cnt==N−1, take timeout action; else cnt+1. No wrap is possible while CNT_WIDTH is sized correctly.
- IDLE: press_i → PRESSED. release_i ignored.
- PRESSED (N=LONG_CYCLES): release_i → WAIT_GAP. Timeout → LONG_HELD, long_o pulse. press_i ignored. If release_i coincides with the timeout edge, release wins and no long_o is emitted.
- WAIT_GAP (N=GAP_CYCLES): press_i → SECOND. Timeout → IDLE, short_o pulse. If press_i coincides with the timeout edge, press wins and no short_o is emitted.
- SECOND: release_i → IDLE, double_o pulse. No timeout. A long hold of the second press is still a double click.
- LONG_HELD (N=REP_CYCLES): hold_o=1. Timeout → rep_o pulse, cnt=0, stay. release_i → IDLE, hold_o=0, no short_o. A release on a timeout edge suppresses that rep_o.
- At most one of short_o/double_o/long_o/rep_o is high in any cycle.

## Timing

- All outputs are registered and change only on clk_i edges (except async reset).
- "Edge k" means the edge that samples an input pulse; the response is visible in the cycle after the stated edge.
- short_o: high after edge r+GAP_CYCLES, where r samples release_i.
- long_o: high after edge p+LONG_CYCLES, where p samples press_i. hold_o rises on the same edge.
- rep_o: high after edges p+LONG_CYCLES+m·REP_CYCLES, for m≥1.
- double_o: high after the edge sampling the second release_i (1-cycle latency).
- hold_o: falls after the edge sampling release_i in LONG_HELD.
- Every pulse lasts exactly one cycle.

## Test plan

(LONG_CYCLES=8, GAP_CYCLES=4, REP_CYCLES=3; edges numbered.)

- Short press: press_i@10, release_i@13 → short_o high only after edge 17; no other pulses.
- Long press with repeat: press_i@10, release_i@25 → long_o and hold_o rise after 18; rep_o after 21 and 24; hold_o falls after 25; no short_o.
- Double click: press_i@10, release_i@12, press_i@14, release_i@15 → double_o after 15; no short_o.
- Gap boundary: press_i@10, release_i@12, press_i@16 (timeout edge), release_i@17 → no short_o; double_o after 17.
- Long boundary: press_i@10, release_i@18 (timeout edge) → no long_o; short_o after 22.
- Reset abort: press_i@10, rst_i pulse at edge 20 (in LONG_HELD), release_i@23 → all outputs 0 from reset onward; release ignored; next press_i@30, release_i@31 → short_o after 35.
